// File: rtl/cache_backing_mem_if.sv
// Request/response bundle between the cache controller (master) and the backing memory (slave).
// The master drives requests and rsp_ready. The slave drives req_ready and the response fields.
interface cache_backing_mem_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_we, rsp_rdata
    );
endinterface

// File: rtl/cache_backing_mem.sv
// Backing memory model for cache fills and writes; each word is preset to its own address after reset.
// Commit/capture happens LATENCY edges after accept; one request at a time; the response is held until rsp_ready.
module cache_backing_mem #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    cache_backing_mem_if.slave bus,
    output logic               init_done
);
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [3:0]        cnt, cnt_nxt;
    req_t              req_q, req_nxt;
    logic              rsp_valid_q, rsp_valid_nxt;
    logic              rsp_we_q, rsp_we_nxt;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;
    logic              init_done_q, init_done_nxt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            ptr         <= '0;
            cnt         <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            req_q       <= req_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_we_q    <= rsp_we_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            init_done_q <= init_done_nxt;
        end
    end

    // Storage is never cleared; gating on rst drops any write pending at a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        req_nxt       = req_q;
        rsp_valid_nxt = rsp_valid_q;
        rsp_we_nxt    = rsp_we_q;
        rsp_rdata_nxt = rsp_rdata_q;
        init_done_nxt = init_done_q;
        bus.req_ready = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = req_q.addr;
        mem_wdata     = req_q.wdata;

        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_addr  = ptr;
                mem_wdata = DATA_W'(ptr);
                ptr_nxt   = ptr + 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_nxt     = IDLE;
                    init_done_nxt = 1'b1;
                end
            end
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    req_nxt.we    = bus.req_we;
                    req_nxt.addr  = bus.req_addr;
                    req_nxt.wdata = bus.req_wdata;
                    cnt_nxt       = CNT_LOAD;
                    state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    rsp_valid_nxt = 1'b1;
                    rsp_we_nxt    = req_q.we;
                    state_nxt     = RESP;
                    if (req_q.we) begin
                        mem_we        = 1'b1;
                        rsp_rdata_nxt = req_q.wdata;
                    end else begin
                        rsp_rdata_nxt = mem[req_q.addr];
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign init_done     = init_done_q;
endmodule

// File: tb/tb_cache_backing_mem.sv
// Directed bench for cache_backing_mem: init sweep, read/write latency, hold under backpressure,
// reset mid-write, and back-to-back throughput.
module tb_cache_backing_mem;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int LATENCY = 4;

    logic clk = 1'b0;
    logic rst;
    logic init_done;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] rsp_log[$];

    cache_backing_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_backing_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every response handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) rsp_log.push_back({bus.rsp_we, bus.rsp_rdata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [6:0] addr, input logic [7:0] wd,
                         output int acc_cyc);
        logic rdy;
        acc_cyc       = -1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        for (int i = 0; i < 400; i++) begin
            rdy = bus.req_ready;
            step();
            if (rdy) begin
                acc_cyc = cyc;
                break;
            end
        end
        bus.req_valid = 1'b0;
        check("accept_in_time", 32'(acc_cyc >= 0), 32'd1);
    endtask

    task automatic wait_rsp(output int rsp_cyc);
        rsp_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            if (bus.rsp_valid) begin
                rsp_cyc = cyc;
                break;
            end
            step();
        end
        check("rsp_in_time", 32'(rsp_cyc >= 0), 32'd1);
    endtask

    task automatic take();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int a0, a1, r, c0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_we",    32'(bus.rsp_we),    32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);

        // Init sweep: 128 edges with init_done/req_ready low, then both high
        for (int i = 0; i < 128; i++) begin
            check("init_done_low", 32'(init_done),     32'd0);
            check("init_rdy_low",  32'(bus.req_ready), 32'd0);
            step();
        end
        check("init_done_high", 32'(init_done),     32'd1);
        check("idle_rdy_high",  32'(bus.req_ready), 32'd1);

        // Read of init pattern
        issue(1'b0, 7'h04, 8'h00, a0);
        wait_rsp(r);
        check("rd04_latency", 32'(r - a0),         32'(LATENCY));
        check("rd04_data",    32'(bus.rsp_rdata),  32'h04);
        check("rd04_we",      32'(bus.rsp_we),     32'd0);
        take();
        check("rd04_cleared", 32'(bus.rsp_valid),  32'd0);

        // Write then read-after-write
        issue(1'b1, 7'h04, 8'h5A, a0);
        wait_rsp(r);
        check("wr04_latency", 32'(r - a0),        32'(LATENCY));
        check("wr04_data",    32'(bus.rsp_rdata), 32'h5A);
        check("wr04_we",      32'(bus.rsp_we),    32'd1);
        take();
        issue(1'b0, 7'h04, 8'h00, a0);
        wait_rsp(r);
        check("raw04_data", 32'(bus.rsp_rdata), 32'h5A);
        check("raw04_we",   32'(bus.rsp_we),    32'd0);
        take();

        // Top address with response backpressure and a competing request
        issue(1'b0, 7'h7F, 8'h00, a0);
        wait_rsp(r);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 7'h10;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_data",  32'(bus.rsp_rdata), 32'h7F);
            check("hold_we",    32'(bus.rsp_we),    32'd0);
            check("hold_rdy",   32'(bus.req_ready), 32'd0);
            if (i < 3) step();
        end
        bus.req_valid = 1'b0;
        take();
        check("post_hold_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_hold_idle",  32'(bus.req_ready), 32'd1);

        // Reset two cycles after a write accept: the write must be lost
        issue(1'b1, 7'h08, 8'hFF, a0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        c0 = cyc;
        check("rst2_init_done", 32'(init_done),     32'd0);
        check("rst2_rdy",       32'(bus.req_ready), 32'd0);
        check("rst2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst2_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);

        // Request held through the whole sweep: accepted on the first IDLE edge
        issue(1'b0, 7'h08, 8'h00, a0);
        check("init_hold_accept", 32'(a0 - c0), 32'd129);
        wait_rsp(r);
        check("rd08_after_rst", 32'(bus.rsp_rdata), 32'h08);
        take();

        // Back-to-back reads with rsp_ready held high
        rsp_log.delete();
        bus.rsp_ready = 1'b1;
        issue(1'b0, 7'h00, 8'h00, a0);
        issue(1'b0, 7'h01, 8'h00, a1);
        check("b2b_spacing", 32'(a1 - a0), 32'(LATENCY + 2));
        wait_rsp(r);
        step();
        bus.rsp_ready = 1'b0;
        check("b2b_count", 32'(rsp_log.size()), 32'd2);
        if (rsp_log.size() == 2) begin
            check("b2b_rsp0", 32'(rsp_log[0]), 32'h000);
            check("b2b_rsp1", 32'(rsp_log[1]), 32'h001);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
